ahb_ram_slave_if: RTL and testbench
===================================

Name: ahb_ram_slave_if

Overview:
AHB-Lite slave front-end sitting directly upstream of the data RAM (ram_ahb).
- Accepts pipelined AHB-Lite address/data phases from the interconnect.
- Converts each accepted word transfer into single-cycle RAM strobes (sel_1, wr_en_ram, rd_en_ram) plus word index and write data.
- Returns HRDATA/HREADYOUT/HRESP, inserting one wait state on reads to cover the RAM's registered read, and a two-cycle ERROR response on illegal accesses.

Parameters:
- DEPTH, 5, number of valid RAM words. Legal word index range is 0..DEPTH-1; DEPTH must be ≤ 8.
- IDX_W, 3, word index width. Index is taken from HADDR[IDX_W+1:2].

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- HSEL  in  1  slave select from decoder
- HADDR  in  32  byte address
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  only 3'b010 (word) is legal
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus-level ready
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  32  read data
- sel_1  out  1  RAM select
- wr_en_ram  out  1  RAM write strobe
- rd_en_ram  out  1  RAM read strobe
- wr_data  out  32  RAM write data
- address_ram  out  32  {zeros, word index}
- rd_data  in  32  RAM registered read data

Behaviour:
- Clock and reset: reset is asynchronous and active-high; clk is the clock. All state changes occur on posedge clk.
- Reset values:
  - State is IDLE.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - sel_1, wr_en_ram, rd_en_ram = 0; wr_data=0; address_ram=0.
  - Latched index, direction and error flag are cleared.
  - A reset asserted mid-transfer drops all strobes immediately, and the state returns to IDLE.
- Accept condition: HSEL & HTRANS[1] & HREADY, sampled on posedge clk.
  - On accept, latch the write flag and the index HADDR[IDX_W+1:2].
  - Latch err = (HSIZE != 3'b010) | (HADDR[1:0] != 0) | (index ≥ DEPTH).
- IDLE/BUSY transfers, or HSEL=0: no latch, no RAM access, OKAY with zero wait states.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. On accept: err → ERR1; write → WR; otherwise → RD_REQ.
  - WR (write data phase): sel_1=1, wr_en_ram=1, wr_data=HWDATA, address_ram=latched index. HREADYOUT=1, so the RAM commits at the end of this cycle. Next state: new accept → its target state; otherwise → IDLE.
  - RD_REQ: sel_1=1, rd_en_ram=1, address_ram=latched index, HREADYOUT=0. Always → RD_DATA.
  - RD_DATA: HRDATA=rd_data, HREADYOUT=1, no RAM strobes. Next state: new accept → its target state; otherwise → IDLE.
  - ERR1: HRESP=1, HREADYOUT=0, no strobes. Always → ERR2.
  - ERR2: HRESP=1, HREADYOUT=1. Next state: new accept → its target state; otherwise → IDLE.
- Pipelining: a new address phase may be accepted only in cycles where HREADYOUT=1 (IDLE, WR, RD_DATA, ERR2). Address phases presented during RD_REQ or ERR1 are ignored, since the master sees HREADY low and holds them.
- Latency:
  - Write: 0 wait states.
  - Read: 1 wait state; data is returned 2 cycles after the address phase.
  - Error: 1 wait state plus the ERROR cycle.
- Strobe exclusivity: wr_en_ram and rd_en_ram are never asserted together, and never asserted for an erroneous transfer.
- Read-after-write: a write committed at the end of WR is visible to a read whose RD_REQ follows in the next cycle. No forwarding is needed.
- HRDATA is 0 in every state except RD_DATA.
- address_ram upper bits [31:IDX_W] are always 0.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings: IDLE, BUSY, NONSEQ, SEQ.
  - HRESP_OKAY and HRESP_ERROR.
  - HSIZE_WORD.
  - The FSM state enum for this block: IDLE, WR, RD_REQ, RD_DATA, ERR1, ERR2.
- Single module; no sub-module is warranted. The error check is a small combinational function in the same file.

Test Plan:
1. Reset: assert reset → HREADYOUT=1, HRESP=0, HRDATA=0, all strobes 0. Then NONSEQ read of HADDR 0x10 → wr_en_ram never pulses; one wait cycle; HRDATA=0x0000EEEE, OKAY.
2. Write then read: NONSEQ write to HADDR 0x8 with HWDATA 0x12345678 → one cycle of wr_en_ram=1, address_ram=2, HREADYOUT=1. Following read of 0x8 → HREADYOUT low for one cycle, then HRDATA=0x12345678.
3. Back-to-back pipelined: write 0x0=0xA5A5A5A5, SEQ write 0x4=0x5A5A5A5A, SEQ read 0x0, SEQ read 0x4.
   - Both writes complete with zero wait states.
   - Each read inserts exactly one wait state and returns the written values in order.
4. Out of range: read HADDR 0x14 (index 5) → ERR1 (HRESP=1, HREADYOUT=0), then ERR2 (HRESP=1, HREADYOUT=1). No RAM strobe at any point.
5. Illegal size/alignment: write HADDR 0x2 with HSIZE=000 → two-cycle ERROR; no wr_en_ram; a subsequent read of 0x0 returns its previous contents.
6. Reset mid-read: assert reset during RD_REQ → strobes drop in the same cycle; after release, state is IDLE and HREADYOUT=1; a read of 0x0 returns 0x0000AAAA.

Source files
------------

// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Package : ahb_pkg
// Purpose : Shared AHB-Lite encodings and the FSM state type used by the
//           RAM slave front-end.
// Contents: HTRANS / HRESP / HSIZE encodings, ahb_state_t enum.
// Revision: 1.0 - initial release
// ============================================================================
package ahb_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Only 32-bit word transfers are supported by the RAM
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Slave front-end FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_ERR1    = 3'd4,
    ST_ERR2    = 3'd5
  } ahb_state_t;

endpackage : ahb_pkg
`default_nettype wire

// File: rtl/ahb_ram_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : ahb_ram_slave_if
// Purpose : AHB-Lite slave front-end for the data RAM. Converts accepted word
//           transfers into single-cycle RAM strobes, adds one wait state on
//           reads (registered RAM read) and a two-cycle ERROR response on
//           illegal accesses.
// Ports   : clk, reset (async, active-high)
//           AHB side : HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY ->
//                      HREADYOUT, HRESP, HRDATA
//           RAM side : sel_1, wr_en_ram, rd_en_ram, wr_data, address_ram ->
//                      rd_data
// Revision: 1.0 - initial release
// ============================================================================
module ahb_ram_slave_if
  import ahb_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int IDX_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        sel_1,
  output logic        wr_en_ram,
  output logic        rd_en_ram,
  output logic [31:0] wr_data,
  output logic [31:0] address_ram,
  input  logic [31:0] rd_data
);

  localparam logic [IDX_W:0] C_DEPTH_LIM = DEPTH[IDX_W:0];

  ahb_state_t       r_state;
  ahb_state_t       w_next_state;
  ahb_state_t       w_target;
  logic [IDX_W-1:0] r_idx;
  logic             r_write;
  logic             r_err;
  logic [IDX_W-1:0] w_idx_in;
  logic             w_err_in;
  logic             w_active;
  logic             w_can_accept;
  logic             w_accept;

  // Address bits above the word index do not participate in decoding.
  logic unused_haddr_hi;
  assign unused_haddr_hi = ^HADDR[31:IDX_W+2];

  function automatic logic addr_err(input logic [2:0]       size,
                                    input logic [1:0]       byte_off,
                                    input logic [IDX_W-1:0] idx);
    addr_err = (size != HSIZE_WORD) | (byte_off != 2'b00) |
               ({1'b0, idx} >= C_DEPTH_LIM);
  endfunction

  assign w_idx_in = HADDR[IDX_W+1:2];
  assign w_err_in = addr_err(HSIZE, HADDR[1:0], w_idx_in);
  assign w_active = (HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ);

  // New address phases are only taken while this slave drives HREADYOUT high;
  // during wait cycles the master holds its address phase and it is
  // accepted once the wait is over.
  assign w_can_accept = (r_state == ST_IDLE) | (r_state == ST_WR) |
                        (r_state == ST_RD_DATA) | (r_state == ST_ERR2);
  assign w_accept     = HSEL & w_active & HREADY & w_can_accept;

  assign w_target = w_err_in ? ST_ERR1 : (HWRITE ? ST_WR : ST_RD_REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_idx   <= w_idx_in;
        r_write <= HWRITE;
        r_err   <= w_err_in;
      end
    end
  end

  always_comb begin
    w_next_state = ST_IDLE;
    HREADYOUT    = 1'b1;
    HRESP        = HRESP_OKAY;
    HRDATA       = '0;
    sel_1        = 1'b0;
    wr_en_ram    = 1'b0;
    rd_en_ram    = 1'b0;
    wr_data      = '0;
    address_ram  = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = w_target;
      end
      ST_WR: begin
        // The latched flags can only reach this state clean; gating the
        // strobe on them keeps an errored or read transfer off the RAM.
        sel_1       = ~r_err;
        wr_en_ram   = r_write & ~r_err;
        wr_data     = HWDATA;
        address_ram = {{(32-IDX_W){1'b0}}, r_idx};
        if (w_accept) w_next_state = w_target;
      end
      ST_RD_REQ: begin
        HREADYOUT    = 1'b0;
        sel_1        = ~r_err;
        rd_en_ram    = ~r_write & ~r_err;
        address_ram  = {{(32-IDX_W){1'b0}}, r_idx};
        w_next_state = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        HRDATA = rd_data;
        if (w_accept) w_next_state = w_target;
      end
      ST_ERR1: begin
        HREADYOUT    = 1'b0;
        HRESP        = HRESP_ERROR;
        w_next_state = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP = HRESP_ERROR;
        if (w_accept) w_next_state = w_target;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule : ahb_ram_slave_if
`default_nettype wire

// File: tb/tb_ahb_ram_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : tb_ahb_ram_slave_if
// Purpose : Self-checking bench for ahb_ram_slave_if. A small registered-read
//           RAM model (preset contents, re-initialised by reset) sits behind
//           the slave. Cycle-by-cycle vectors hold bus inputs and the
//           expected slave outputs for that cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ahb_ram_slave_if;

  logic        clk;
  logic        reset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        sel_1;
  logic        wr_en_ram;
  logic        rd_en_ram;
  logic [31:0] wr_data;
  logic [31:0] address_ram;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  ahb_ram_slave_if #(.DEPTH(5), .IDX_W(3)) dut (
    .clk(clk), .reset(reset),
    .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
    .sel_1(sel_1), .wr_en_ram(wr_en_ram), .rd_en_ram(rd_en_ram),
    .wr_data(wr_data), .address_ram(address_ram), .rd_data(rd_data)
  );

  // Single-slave system: the bus ready is this slave's ready.
  assign hready = hreadyout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, preset contents restored on reset.
  logic [31:0] mem [0:7];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= 32'h0000AAAA; mem[1] <= 32'h0000BBBB;
      mem[2] <= 32'h0000CCCC; mem[3] <= 32'h0000DDDD;
      mem[4] <= 32'h0000EEEE; mem[5] <= 32'h0;
      mem[6] <= 32'h0;        mem[7] <= 32'h0;
      rd_data <= 32'h0;
    end else begin
      if (sel_1 && wr_en_ram) mem[address_ram[2:0]] <= wr_data;
      if (sel_1 && rd_en_ram) rd_data <= mem[address_ram[2:0]];
    end
  end

  typedef struct {
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
    logic        sel;
    logic        wr;
    logic        rd;
    logic [31:0] aram;
    logic [31:0] wdat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic s, logic [1:0] tr, logic w, logic [2:0] sz,
                             logic [31:0] a, logic [31:0] wd,
                             logic rdy, logic resp, logic [31:0] rdat,
                             logic es, logic ew, logic er,
                             logic [31:0] ea, logic [31:0] ewd);
    vec_t r;
    r.hsel = s; r.htrans = tr; r.hwrite = w; r.hsize = sz;
    r.haddr = a; r.hwdata = wd; r.rdy = rdy; r.resp = resp; r.rdata = rdat;
    r.sel = es; r.wr = ew; r.rd = er; r.aram = ea; r.wdat = ewd;
    return r;
  endfunction

  function automatic logic [127:0] pack_exp(vec_t x);
    return {27'd0, x.rdy, x.resp, x.rdata, x.sel, x.wr, x.rd, x.aram, x.wdat};
  endfunction

  function automatic logic [127:0] pack_act();
    return {27'd0, hreadyout, hresp, hrdata, sel_1, wr_en_ram, rd_en_ram,
            address_ram, wr_data};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
    haddr = 32'h0; hwdata = 32'h0;
  endtask

  localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] W = 3'b010;

  initial begin
    drive_idle();
    reset = 1'b1;
    #2;
    // hreadyout,hresp,hrdata,sel,wr,rd,address_ram,wr_data all at reset values
    check("reset_outputs", pack_act(), {27'd0, 1'b1, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Read index 4 (last legal word): one wait state, preset data
    vecs.push_back(v(1,NS,0,W,32'h10,0,        1,0,0,            0,0,0,0,0));
    vecs.push_back(v(0,ID,0,W,0,0,             0,0,0,            1,0,1,4,0));
    vecs.push_back(v(0,ID,0,W,0,0,             1,0,32'h0000EEEE, 0,0,0,0,0));
    vecs.push_back(v(0,ID,0,W,0,0,             1,0,0,            0,0,0,0,0));
    // Write 0x8 then pipelined read of 0x8 (read-after-write)
    vecs.push_back(v(1,NS,1,W,32'h8,0,         1,0,0,            0,0,0,0,0));
    vecs.push_back(v(1,NS,0,W,32'h8,32'h12345678, 1,0,0,         1,1,0,2,32'h12345678));
    vecs.push_back(v(0,ID,0,W,0,0,             0,0,0,            1,0,1,2,0));
    vecs.push_back(v(0,ID,0,W,0,0,             1,0,32'h12345678, 0,0,0,0,0));
    // Back-to-back: W0, W4, R0, R4
    vecs.push_back(v(1,NS,1,W,32'h0,0,         1,0,0,            0,0,0,0,0));
    vecs.push_back(v(1,SQ,1,W,32'h4,32'hA5A5A5A5, 1,0,0,         1,1,0,0,32'hA5A5A5A5));
    vecs.push_back(v(1,SQ,0,W,32'h0,32'h5A5A5A5A, 1,0,0,         1,1,0,1,32'h5A5A5A5A));
    vecs.push_back(v(1,SQ,0,W,32'h4,0,         0,0,0,            1,0,1,0,0));
    vecs.push_back(v(1,SQ,0,W,32'h4,0,         1,0,32'hA5A5A5A5, 0,0,0,0,0));
    vecs.push_back(v(0,ID,0,W,0,0,             0,0,0,            1,0,1,1,0));
    vecs.push_back(v(0,ID,0,W,0,0,             1,0,32'h5A5A5A5A, 0,0,0,0,0));
    vecs.push_back(v(0,ID,0,W,0,0,             1,0,0,            0,0,0,0,0));
    // Out of range read, index 5
    vecs.push_back(v(1,NS,0,W,32'h14,0,        1,0,0,            0,0,0,0,0));
    vecs.push_back(v(0,ID,0,W,0,0,             0,1,0,            0,0,0,0,0));
    vecs.push_back(v(0,ID,0,W,0,0,             1,1,0,            0,0,0,0,0));
    vecs.push_back(v(0,ID,0,W,0,0,             1,0,0,            0,0,0,0,0));
    // Illegal size + misaligned write, then pipelined read of 0x0 from ERR2
    vecs.push_back(v(1,NS,1,3'b000,32'h2,0,    1,0,0,            0,0,0,0,0));
    vecs.push_back(v(0,ID,0,W,0,32'hDEADBEEF,  0,1,0,            0,0,0,0,0));
    vecs.push_back(v(1,NS,0,W,32'h0,0,         1,1,0,            0,0,0,0,0));
    vecs.push_back(v(0,ID,0,W,0,0,             0,0,0,            1,0,1,0,0));
    vecs.push_back(v(0,ID,0,W,0,0,             1,0,32'hA5A5A5A5, 0,0,0,0,0));
    // Unselected and BUSY transfers are ignored; 0x4 keeps its data
    vecs.push_back(v(0,NS,1,W,32'h4,0,         1,0,0,            0,0,0,0,0));
    vecs.push_back(v(1,BZ,1,W,32'h4,32'h11111111, 1,0,0,         0,0,0,0,0));
    vecs.push_back(v(1,NS,0,W,32'h4,32'h22222222, 1,0,0,         0,0,0,0,0));
    vecs.push_back(v(0,ID,0,W,0,0,             0,0,0,            1,0,1,1,0));
    vecs.push_back(v(0,ID,0,W,0,0,             1,0,32'h5A5A5A5A, 0,0,0,0,0));
    // Index 7 is beyond DEPTH as well
    vecs.push_back(v(1,NS,1,W,32'h1C,0,        1,0,0,            0,0,0,0,0));
    vecs.push_back(v(0,ID,0,W,0,32'h33333333,  0,1,0,            0,0,0,0,0));
    vecs.push_back(v(0,ID,0,W,0,0,             1,1,0,            0,0,0,0,0));
    vecs.push_back(v(0,ID,0,W,0,0,             1,0,0,            0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      hsel = vecs[i].hsel; htrans = vecs[i].htrans; hwrite = vecs[i].hwrite;
      hsize = vecs[i].hsize; haddr = vecs[i].haddr; hwdata = vecs[i].hwdata;
      #1;
      check($sformatf("vec%0d", i), pack_act(), pack_exp(vecs[i]));
    end

    // Reset in the middle of a read: strobes drop without waiting for a clock
    @(negedge clk);
    hsel = 1'b1; htrans = NS; hwrite = 1'b0; haddr = 32'h0;
    @(negedge clk);
    drive_idle();
    #1;
    check("midrd_rd_req", {127'd0, rd_en_ram}, 128'd1);
    reset = 1'b1;
    #1;
    check("midrd_strobes", {125'd0, sel_1, wr_en_ram, rd_en_ram}, 128'd0);
    check("midrd_ready", {127'd0, hreadyout}, 128'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_idle", {94'd0, hreadyout, hresp, hrdata}, {94'd0, 1'b1, 1'b0, 32'h0});
    @(negedge clk);
    hsel = 1'b1; htrans = NS; hwrite = 1'b0; haddr = 32'h0;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    #1;
    check("post_reset_read", {94'd0, hreadyout, hresp, hrdata}, {94'd0, 1'b1, 1'b0, 32'h0000AAAA});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ahb_ram_slave_if
`default_nettype wire
